// File: rtl/vga_pattern_timing.sv
// VGA timing generator with a frame-synchronised test-pattern source.
// Feeds a 1-bit pixel plus registered sync, active flag and coordinates to the colour expander.
module vga_pattern_timing #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SQ_LOG2  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       color_out,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] H_ACT_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic [1:0]       mode_q;
  logic             tick;
  logic             h_wrap;
  logic             v_wrap;
  logic             hs_n;
  logic             vs_n;
  logic             active;
  logic             pattern;
  logic             color;
  logic             origin;
  logic             origin_q;

  // With CLK_DIV = 1 the divider stays at 0, which equals CLK_DIV-1, so tick is permanently high.
  assign tick   = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);
  assign origin = (h_cnt == 10'd0) && (v_cnt == 10'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // The pattern mode is latched only on the end-of-frame tick so a frame never mixes patterns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt  <= '0;
      v_cnt  <= '0;
      mode_q <= '0;
    end else if (tick) begin
      if (h_wrap) begin
        h_cnt <= '0;
        if (v_wrap) begin
          v_cnt  <= '0;
          mode_q <= mode;
        end else begin
          v_cnt <= v_cnt + 10'd1;
        end
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  always_comb begin
    hs_n    = 1'b1;
    vs_n    = 1'b1;
    pattern = 1'b0;
    if ((h_cnt >= HS_START) && (h_cnt < HS_END)) hs_n = 1'b0;
    if ((v_cnt >= VS_START) && (v_cnt < VS_END)) vs_n = 1'b0;
    active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    case (mode_q)
      2'd1:    pattern = h_cnt[SQ_LOG2] ^ v_cnt[SQ_LOG2];
      2'd2:    pattern = (h_cnt == 10'd0) || (h_cnt == H_ACT_LAST) ||
                         (v_cnt == 10'd0) || (v_cnt == V_ACT_LAST);
      2'd3:    pattern = h_cnt[SQ_LOG2];
      default: pattern = 1'b0;
    endcase
    color = pattern && active;
  end

  // frame_start fires on the first clock the registered coordinates read (0,0), including right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      color_out   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      origin_q    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hs_n;
      vsync       <= vs_n;
      video_on    <= active;
      color_out   <= color;
      pix_x       <= h_cnt;
      pix_y       <= v_cnt;
      origin_q    <= origin;
      frame_start <= origin && !origin_q;
    end
  end

endmodule
